// File: rtl/gift_pipe_arbiter.sv
// gift_pipe_arbiter: round-robin A/B sharing of one pipelined GIFT-128 decryptor,
// with a tag shift register that routes each returning block to its requester.
module gift_pipe_arbiter #(
  parameter int LAT = 40,
  parameter int CNT_W = 6
) (
  input  logic         inClk,
  input  logic         inRstN,
  input  logic         inReqA,
  input  logic         inReqB,
  input  logic [127:0] inKeyA,
  input  logic [127:0] inKeyB,
  input  logic [127:0] inDataA,
  input  logic [127:0] inDataB,
  output logic         outAckA,
  output logic         outAckB,
  output logic         outPipeWr,
  output logic [127:0] outPipeKey,
  output logic [127:0] outPipeData,
  input  logic [127:0] inPipeData,
  input  logic         inPipeValid,
  output logic         outValidA,
  output logic         outValidB,
  output logic [127:0] outData,
  input  logic         inFlush,
  output logic         outFlushDone,
  output logic         outBusy,
  output logic         outErr
);
  typedef enum logic [1:0] {BLANK, RUN, DRAIN} stateT;
  stateT state, stateNext;
  logic [CNT_W-1:0] blankCnt, count;
  logic [LAT-1:0] tagV, tagId;
  logic rrB, pipeId, grantA, grantB, grant, flushDoneNext, tailV, tailId, retOn, retHit;
  assign tailV = tagV[LAT-1];
  assign tailId = tagId[LAT-1];
  // The decryptor has no reset, so its output is only trusted once BLANK has flushed it.
  assign retOn = state != BLANK;
  assign retHit = retOn & inPipeValid & tailV;
  assign grant = grantA | grantB;
  assign outAckA = grantA;
  assign outAckB = grantB;
  assign outBusy = count != '0;
  always_comb begin
    stateNext = state;
    grantA = 1'b0;
    grantB = 1'b0;
    flushDoneNext = 1'b0;
    case (state)
      BLANK: stateNext = (blankCnt == CNT_W'(LAT)) ? RUN : BLANK;
      RUN: begin
        stateNext = inFlush ? DRAIN : RUN;
        grantA = ~inFlush & inReqA & (~inReqB | ~rrB);
        grantB = ~inFlush & inReqB & (~inReqA | rrB);
      end
      DRAIN: begin
        stateNext = (count == '0) ? RUN : DRAIN;
        flushDoneNext = count == '0;
      end
      default: stateNext = BLANK;
    endcase
  end
  always_ff @(posedge inClk or negedge inRstN)
    if (!inRstN) begin
      state <= BLANK;
      blankCnt <= '0;
      count <= '0;
      rrB <= 1'b0;
      pipeId <= 1'b0;
      tagV <= '0;
      tagId <= '0;
      outPipeWr <= 1'b0;
      outPipeKey <= '0;
      outPipeData <= '0;
      outValidA <= 1'b0;
      outValidB <= 1'b0;
      outData <= '0;
      outFlushDone <= 1'b0;
      outErr <= 1'b0;
    end else begin
      state <= stateNext;
      blankCnt <= (state == BLANK) ? blankCnt + 1'b1 : '0;
      rrB <= grant ? grantA : rrB;
      outPipeWr <= grant;
      if (grant) begin
        outPipeKey <= grantB ? inKeyB : inKeyA;
        outPipeData <= grantB ? inDataB : inDataA;
        pipeId <= grantB;
      end
      tagV <= {tagV[LAT-2:0], outPipeWr};
      tagId <= {tagId[LAT-2:0], pipeId};
      count <= count + CNT_W'(grant) - CNT_W'(tailV);
      outValidA <= retHit & ~tailId;
      outValidB <= retHit & tailId;
      if (retHit) outData <= inPipeData;
      outErr <= outErr | (retOn & (inPipeValid != tailV));
      outFlushDone <= flushDoneNext;
    end
endmodule
